// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg
// ----------------------------------------------------------------------------
// Shared CPU-wide types and widths.
//   PC_W : program-counter / instruction-address width
//   pc_t : program-counter value type (return addresses, next-PC)
// Revision: 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int PC_W = 10;

  typedef logic [PC_W-1:0] pc_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/link_stack.sv
`default_nettype none
// ============================================================================
// link_stack
// ----------------------------------------------------------------------------
// Hardware return-address stack. It sits beside the program counter and
// returns its top entry on rl.
//   - A taken jump2sub pushes npc.
//   - A taken retFsub pops.
//   - rl shows the top entry combinationally, so the PC can load it on the
//     same edge as the pop.
//
// Ports
//   clk       in   system clock; all state changes on posedge
//   reset     in   asynchronous active-high clear
//   start     in   synchronous clear; overrides every strobe in its cycle
//   branch    in   branch strobe; suppresses jump2sub/retFsub
//   jump2sub  in   call strobe (push)
//   retFsub   in   return strobe (pop)
//   npc       in   return address (PC+1)
//   rl        out  top-of-stack return address; 0 when empty
//   depth     out  number of valid entries, 0..DEPTH
//   empty     out  depth == 0
//   full      out  depth == DEPTH
//   err       out  sticky overflow/underflow flag
//
// Configuration macro
//   LINK_STACK_ERR_EN : when defined, err is set by any overflow push or
//                       underflow pop and holds until reset or start.
//                       When undefined, err is constant 0.
// Revision: 1.0  initial release
// ============================================================================
module link_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,      // power of two, >= 2
  parameter int AW    = PC_W    // must equal PC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    branch,
  input  logic                    jump2sub,
  input  logic                    retFsub,
  input  logic [AW-1:0]           npc,
  output logic [AW-1:0]           rl,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    empty,
  output logic                    full,
  output logic                    err
);

  localparam int                c_sp_w = $clog2(DEPTH);
  localparam logic [c_sp_w:0]   c_full = (c_sp_w+1)'(DEPTH);

  pc_t               mem [DEPTH];
  logic [c_sp_w-1:0] sp_q, sp_d, top_idx_w;
  logic [c_sp_w:0]   depth_q, depth_d;
  logic              push_w, pop_w, empty_w, full_w;

  // Same priority as the PC: branch > jump2sub > retFsub, and start kills all.
  assign push_w  = jump2sub & ~branch & ~start;
  assign pop_w   = retFsub & ~jump2sub & ~branch & ~start;

  assign empty_w = (depth_q == '0);
  assign full_w  = (depth_q == c_full);

  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    if (push_w) begin
      // A push while full wraps over the oldest entry; depth saturates.
      sp_d = sp_q + c_sp_w'(1);
      if (!full_w) begin
        depth_d = depth_q + (c_sp_w+1)'(1);
      end
    end else if (pop_w && !empty_w) begin
      // A pop while empty leaves the pointer alone so rl stays 0.
      sp_d    = sp_q - c_sp_w'(1);
      depth_d = depth_q - (c_sp_w+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q    <= '0;
      depth_q <= '0;
    end else if (start) begin
      sp_q    <= '0;
      depth_q <= '0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

  // Storage has no reset; the entries are only visible through depth_q.
  always_ff @(posedge clk) begin
    if (push_w) begin
      mem[sp_q] <= pc_t'(npc);
    end
  end

  assign top_idx_w = sp_q - c_sp_w'(1);
  assign rl        = empty_w ? '0 : AW'(mem[top_idx_w]);
  assign depth     = depth_q;
  assign empty     = empty_w;
  assign full      = full_w;

`ifdef LINK_STACK_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else if ((push_w && full_w) || (pop_w && empty_w)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule : link_stack
`default_nettype wire
